secure_router_q: RTL and testbench

- Parametrised, buffered successor to the combinational 4-way secure router.
- Accepts a 4-bit data nibble plus a destination index over a valid/ready handshake and Hamming(7,4)-encodes the nibble.
- Queues the 7-bit codeword in a per-port FIFO and presents it on the selected output port with its own valid/ready handshake.
- Adds NUM_PORTS scaling, buffering, back-pressure and a broadcast mode.

---
 rtl/secure_router_q_pkg.sv | 24 ++
 rtl/sr_fifo.sv | 65 ++++++
 rtl/secure_router_q.sv | 96 +++++++++
 tb/tb_secure_router_q.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_router_q_pkg.sv
// secure_router_q_pkg: shared definitions for the buffered secure router.
//   CODE_W  - Hamming(7,4) codeword width
//   DATA_W  - data nibble width
//   STAT_W  - per-port pop statistics counter width
//   hamming74_enc() - nibble to codeword encoder. The router and its bench
//                     scoreboard both use it.
// Data bit naming: d0 = data[3], d1 = data[2], d2 = data[1], d3 = data[0].
package secure_router_q_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int STAT_W = 8;

  // Codeword layout [6:0] = {d0, d1, d2, p_a, d3, p_b, p_c}
  function automatic logic [CODE_W-1:0] hamming74_enc(input logic [DATA_W-1:0] data);
    logic d0, d1, d2, d3;
    d0 = data[3];
    d1 = data[2];
    d2 = data[1];
    d3 = data[0];
    return {d0, d1, d2, d0 ^ d1 ^ d2, d3, d0 ^ d1 ^ d3, d0 ^ d2 ^ d3};
  endfunction

endpackage

// File: rtl/sr_fifo.sv
// sr_fifo: show-ahead synchronous FIFO, one per router output port.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (pointers and count only)
//   push   - write wdata; ignored when full
//   wdata  - entry to write
//   pop    - drop the head entry; ignored when empty
//   rdata  - head entry (valid while !empty)
//   full   - DEPTH entries held
//   empty  - no entries held
module sr_fifo
  import secure_router_q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/secure_router_q.sv
// secure_router_q: Hamming(7,4)-encodes an input nibble and queues the
// codeword in the FIFO of one (unicast) or every (broadcast) output port.
// Optional build macro: SECURE_ROUTER_Q_STATS_EN adds per-port pop counters.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   in_valid/in_ready  - input handshake; in_ready does not depend on in_valid
//   in_dest, in_bcast  - destination index, broadcast-to-all flag
//   in_data            - data nibble
//   out_valid[p]       - port p holds a word
//   out_ready[p]       - sink on port p takes the word
//   out_code           - port p codeword in bits [7p+6:7p]; 0 when empty
//   stat_cnt           - (macro only) port p saturating pop count in [8p+7:8p]
module secure_router_q
  import secure_router_q_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter int DEST_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DEST_W-1:0]           in_dest,
  input  logic                        in_bcast,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [CODE_W*NUM_PORTS-1:0] out_code
`ifdef SECURE_ROUTER_Q_STATS_EN
  ,
  output logic [STAT_W*NUM_PORTS-1:0] stat_cnt
`endif
);

  logic [CODE_W-1:0]    code;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [CODE_W-1:0]    rdata [NUM_PORTS];
  logic                 accept;

`ifdef SECURE_ROUTER_Q_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction
`endif

  assign code = hamming74_enc(in_data);

  // A broadcast needs room everywhere so it is never partially delivered.
  // A full port refuses input even if it pops this cycle (no pass-through).
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (in_bcast) in_ready = ~|full;
      else          in_ready = !full[in_dest];
    end
  end

  assign accept = in_valid && in_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign push[p]      = accept && (in_bcast || (in_dest == DEST_W'(p)));
    assign out_valid[p] = rst_n && !empty[p];
    assign pop[p]       = out_valid[p] && out_ready[p];
    assign out_code[CODE_W*p +: CODE_W] = out_valid[p] ? rdata[p] : '0;

    sr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CODE_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[p]),
      .wdata (code),
      .pop   (pop[p]),
      .rdata (rdata[p]),
      .full  (full[p]),
      .empty (empty[p])
    );

`ifdef SECURE_ROUTER_Q_STATS_EN
    logic [STAT_W-1:0] pop_cnt;

    always_ff @(posedge clk) begin
      if (!rst_n)      pop_cnt <= '0;
      else if (pop[p]) pop_cnt <= sat_inc(pop_cnt);
    end

    assign stat_cnt[STAT_W*p +: STAT_W] = pop_cnt;
`endif
  end

endmodule

// File: tb/tb_secure_router_q.sv
// tb_secure_router_q: scoreboard bench for secure_router_q (NUM_PORTS=4, DEPTH=4).
// Inputs change 1 time unit after the rising edge; the scoreboard samples on
// the falling edge, checks outputs against per-port expected queues and then
// applies the transfers that the next rising edge will perform.
module tb_secure_router_q;
  import secure_router_q_pkg::*;

  localparam int NP = 4;
  localparam int DP = 4;
  localparam int DW = $clog2(NP);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_dest = '0;
  logic            in_bcast = 1'b0;
  logic [3:0]      in_data = '0;
  logic [NP-1:0]   out_valid;
  logic [NP-1:0]   out_ready = '0;
  logic [7*NP-1:0] out_code;
`ifdef SECURE_ROUTER_Q_STATS_EN
  logic [8*NP-1:0] stat_cnt;
`endif

  secure_router_q #(
    .NUM_PORTS (NP),
    .DEPTH     (DP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_bcast  (in_bcast),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code)
`ifdef SECURE_ROUTER_Q_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [6:0]  exp_q [NP][$];
  int unsigned stat_m [NP];

  always @(negedge clk) begin : scoreboard
    logic exp_rdy;
    logic all_free;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_code", out_code, 0);
      for (int p = 0; p < NP; p++) begin
        exp_q[p].delete();
        stat_m[p] = 0;
      end
    end else begin
      all_free = 1'b1;
      for (int p = 0; p < NP; p++) begin
        check($sformatf("out_valid[%0d]", p), out_valid[p], exp_q[p].size() != 0);
        check($sformatf("out_code[%0d]", p), out_code[7*p +: 7],
              (exp_q[p].size() != 0) ? exp_q[p][0] : 7'd0);
`ifdef SECURE_ROUTER_Q_STATS_EN
        check($sformatf("stat_cnt[%0d]", p), stat_cnt[8*p +: 8], stat_m[p]);
`endif
        if (exp_q[p].size() == DP) all_free = 1'b0;
      end
      exp_rdy = in_bcast ? all_free : (exp_q[int'(in_dest)].size() != DP);
      check("in_ready", in_ready, exp_rdy);
      // pops before pushes so an empty port never pops the word entering it
      for (int p = 0; p < NP; p++) begin
        if (exp_q[p].size() != 0 && out_ready[p]) begin
          void'(exp_q[p].pop_front());
          if (stat_m[p] < 255) stat_m[p]++;
        end
      end
      if (in_valid && exp_rdy) begin
        for (int p = 0; p < NP; p++)
          if (in_bcast || int'(in_dest) == p) exp_q[p].push_back(hamming74_enc(in_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int dest, input logic bc, input logic [3:0] d, output logic rdy);
    in_valid = 1'b1;
    in_dest  = DW'(dest);
    in_bcast = bc;
    in_data  = d;
    @(negedge clk);
    rdy = in_ready;
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic r;
    repeat (3) step();
    rst_n = 1'b1;

    // single unicast to port 2
    send(2, 1'b0, 4'b1011, r);
    check("t1_rdy", r, 1);
    @(negedge clk);
    check("t1_valid", out_valid, 4'b0100);
    check("t1_code_p2", out_code[20:14], 7'b1010101);
    check("t1_others", {out_code[27:21], out_code[13:0]}, 0);
    step();
    out_ready = 4'b0100;
    step();
    out_ready = '0;

    // back-pressure on port 1, port 3 unaffected
    for (int i = 0; i < 4; i++) begin
      send(1, 1'b0, 4'(i + 1), r);
      check("t2_fill_rdy", r, 1);
    end
    send(1, 1'b0, 4'd5, r);
    check("t2_full_rdy", r, 0);
    send(3, 1'b0, 4'd9, r);
    check("t2_other_rdy", r, 1);
    out_ready[1] = 1'b1;
    send(1, 1'b0, 4'd6, r);           // pops word 1 in the same cycle
    check("t2_full_pop_rdy", r, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("t2_drain", out_code[13:7], hamming74_enc(4'(i + 1)));
      step();
    end
    @(negedge clk);
    check("t2_p1_empty", out_valid[1], 0);
    step();
    out_ready = 4'b1000;
    step();
    out_ready = '0;

    // broadcast to empty ports, then refused with port 0 full
    send(0, 1'b1, 4'b0110, r);
    check("t3_bc_rdy", r, 1);
    @(negedge clk);
    check("t3_bc_valid", out_valid, 4'hF);
    for (int p = 0; p < NP; p++)
      check("t3_bc_code", out_code[7*p +: 7], 7'b0110011);
    step();
    out_ready = '1;
    step();
    out_ready = '0;
    for (int i = 0; i < 4; i++) send(0, 1'b0, 4'(i), r);
    send(2, 1'b0, 4'hA, r);
    check("t3_uni_rdy", r, 1);
    send(1, 1'b1, 4'h6, r);
    check("t3_bc_full_rdy", r, 0);
    @(negedge clk);
    check("t3_no_partial", out_valid, 4'b0101);
    step();
    out_ready = '1;
    repeat (5) step();
    out_ready = '0;

    // simultaneous push and pop on port 2 holding two entries
    send(2, 1'b0, 4'd3, r);
    send(2, 1'b0, 4'd4, r);
    out_ready[2] = 1'b1;
    send(2, 1'b0, 4'd5, r);
    check("t4_rdy", r, 1);
    out_ready = '0;
    @(negedge clk);
    check("t4_head", out_code[20:14], hamming74_enc(4'd4));
    step();
    out_ready[2] = 1'b1;
    step();
    @(negedge clk);
    check("t4_second", out_code[20:14], hamming74_enc(4'd5));
    step();
    out_ready = '0;
    @(negedge clk);
    check("t4_empty", out_valid[2], 0);
    step();

    // reset mid-stream with a word in flight
    send(0, 1'b0, 4'd1, r);
    send(1, 1'b0, 4'd2, r);
    send(0, 1'b0, 4'd3, r);
    in_valid = 1'b1;
    in_dest  = 2'd2;
    in_data  = 4'd7;
    rst_n    = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_code", out_code, 0);
    step();
    rst_n = 1'b1;
    send(3, 1'b0, 4'hC, r);
    check("t5_rdy", r, 1);
    @(negedge clk);
    check("t5_alone", out_valid, 4'b1000);
    check("t5_code", out_code[27:21], hamming74_enc(4'hC));
    step();
    out_ready = '1;
    step();
    out_ready = '0;

`ifdef SECURE_ROUTER_Q_STATS_EN
    // saturating pop counter
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 300; i++) send(0, 1'b0, 4'(i), r);
    repeat (2) step();
    @(negedge clk);
    check("stat_sat_p0", stat_cnt[7:0], 8'd255);
    check("stat_others", stat_cnt[31:8], 0);
    step();
    out_ready = '0;
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_dest   = DW'($urandom);
      in_bcast  = ($urandom_range(0, 7) == 0);
      in_data   = 4'($urandom);
      out_ready = NP'($urandom);
      step();
    end
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = '1;
    repeat (8) step();
    @(negedge clk);
    check("final_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
